// File: rtl/bp_pkg.sv
// Shared definitions for the 2-bit branch predictor.
//   - counter-state encodings for the 2-bit saturating counters
//   - controller FSM state type
//   - PC-to-table-index extraction helper
package bp_pkg;

  localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'b00;
  localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
  localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
  localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bht_state_e;

  // Word-aligned PC: drop PC[1:0], keep the next index_bits bits.
  function automatic logic [31:0] pc_to_index(input logic [63:0] pc,
                                              input int unsigned index_bits);
    logic [63:0] mask;
    mask = (64'd1 << index_bits) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

endpackage

// File: rtl/branchPredictor2Bit.sv
// Combinational next-state logic of one 2-bit saturating counter.
// Ports:
//   currentState in  2  counter value before the update
//   branchTaken  in  1  resolved outcome
//   nextState    out 2  counter value after the update
module branchPredictor2Bit
  import bp_pkg::*;
(
  input  logic [1:0] currentState,
  input  logic       branchTaken,
  output logic [1:0] nextState
);

  always_comb begin
    nextState = currentState;
    unique case (currentState)
      STRONGLY_NOT_TAKEN: nextState = branchTaken ? WEAKLY_NOT_TAKEN : STRONGLY_NOT_TAKEN;
      WEAKLY_NOT_TAKEN:   nextState = branchTaken ? WEAKLY_TAKEN     : STRONGLY_NOT_TAKEN;
      WEAKLY_TAKEN:       nextState = branchTaken ? STRONGLY_TAKEN   : WEAKLY_NOT_TAKEN;
      STRONGLY_TAKEN:     nextState = branchTaken ? STRONGLY_TAKEN   : WEAKLY_TAKEN;
      default:            nextState = currentState;
    endcase
  end

endmodule

// File: rtl/bht_controller.sv
// Pattern-history-table controller: flop array of 2-bit counters with one
// lookup port (fetch) and one resolved-branch update port (execute), an
// init sweep after reset, and saturating lookup/mispredict statistics.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   predValid/predPC/predReady      lookup request handshake
//   predRespValid/prediction/predState  registered lookup response
//   updValid/updPC/updTaken/updPredicted/updReady  update handshake
//   busy                            init sweep in progress
//   predCount/mispredCount          saturating statistics
module bht_controller
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned PC_BITS    = 32,
  parameter logic [1:0]  INIT_STATE = WEAKLY_TAKEN,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                predValid,
  input  logic [PC_BITS-1:0]  predPC,
  output logic                predReady,
  output logic                predRespValid,
  output logic                prediction,
  output logic [1:0]          predState,
  input  logic                updValid,
  input  logic [PC_BITS-1:0]  updPC,
  input  logic                updTaken,
  input  logic                updPredicted,
  output logic                updReady,
  output logic                busy,
  output logic [CNT_BITS-1:0] predCount,
  output logic [CNT_BITS-1:0] mispredCount
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  bht_state_e              state_q, state_d;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [1:0]              bht_q [ENTRIES];
  logic [INDEX_BITS-1:0]   pred_idx, upd_idx;
  logic [1:0]              upd_next;
  logic                    pred_acc, upd_acc, sweep_last;

  assign pred_idx   = INDEX_BITS'(pc_to_index(64'(predPC), INDEX_BITS));
  assign upd_idx    = INDEX_BITS'(pc_to_index(64'(updPC), INDEX_BITS));
  assign pred_acc   = predValid & predReady;
  assign upd_acc    = updValid & updReady;
  assign sweep_last = (idx_q == INDEX_BITS'(ENTRIES - 1));

  branchPredictor2Bit u_next (
    .currentState (bht_q[upd_idx]),
    .branchTaken  (updTaken),
    .nextState    (upd_next)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  // FSM next state: leave INIT on the edge that writes the last entry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (sweep_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Handshake/status outputs registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b1;
      predReady <= 1'b0;
      updReady  <= 1'b0;
      idx_q     <= '0;
    end else begin
      busy      <= (state_d == INIT);
      predReady <= (state_d == RUN);
      updReady  <= (state_d == RUN);
      if (state_q == INIT) idx_q <= idx_q + INDEX_BITS'(1);
    end
  end

  // Lookup response; prediction/predState hold when no lookup is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      predRespValid <= 1'b0;
      prediction    <= 1'b0;
      predState     <= STRONGLY_NOT_TAKEN;
    end else begin
      predRespValid <= pred_acc;
      if (pred_acc) begin
        predState  <= bht_q[pred_idx];
        prediction <= bht_q[pred_idx][1];
      end
    end
  end

  // Saturating statistics; handshakes are low during INIT so they freeze there
  always_ff @(posedge clk) begin
    if (reset) begin
      predCount    <= '0;
      mispredCount <= '0;
    end else begin
      if (pred_acc && (predCount != '1))
        predCount <= predCount + CNT_BITS'(1);
      if (upd_acc && (updPredicted != updTaken) && (mispredCount != '1))
        mispredCount <= mispredCount + CNT_BITS'(1);
    end
  end

  // Table write port: sweep during INIT, counter update during RUN.
  // Not reset; the sweep overwrites every entry.
  always_ff @(posedge clk) begin
    if (state_q == INIT)
      bht_q[idx_q] <= INIT_STATE;
    else if (upd_acc)
      bht_q[upd_idx] <= upd_next;
  end

endmodule

// File: tb/tb_bht_controller.sv
// Directed bench for bht_controller: reset values, init sweep, a table of
// per-cycle update/lookup vectors, mid-sweep reset, ignored INIT requests
// and statistics including saturation.
module tb_bht_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        predValid;
  logic [31:0] predPC;
  logic        predReady;
  logic        predRespValid;
  logic        prediction;
  logic [1:0]  predState;
  logic        updValid;
  logic [31:0] updPC;
  logic        updTaken;
  logic        updPredicted;
  logic        updReady;
  logic        busy;
  logic [15:0] predCount;
  logic [15:0] mispredCount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bht_controller dut (
    .clk           (clk),
    .reset         (reset),
    .predValid     (predValid),
    .predPC        (predPC),
    .predReady     (predReady),
    .predRespValid (predRespValid),
    .prediction    (prediction),
    .predState     (predState),
    .updValid      (updValid),
    .updPC         (updPC),
    .updTaken      (updTaken),
    .updPredicted  (updPredicted),
    .updReady      (updReady),
    .busy          (busy),
    .predCount     (predCount),
    .mispredCount  (mispredCount)
  );

  typedef struct {
    logic        uv;
    logic        ut;
    logic        up;
    logic [31:0] upc;
    logic        pv;
    logic [31:0] ppc;
    logic        exp_rv;
    logic [1:0]  exp_ps;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  // Looks up every index once and counts responses that are not weakly taken
  task automatic sweep_check(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      predValid = 1'b1;
      predPC    = 32'(i) << 2;
      step();
      if (predRespValid !== 1'b1 || predState !== 2'b10 || prediction !== 1'b1) bad++;
    end
    predValid = 1'b0;
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    int cycles;
    int resp_seen;

    reset = 1'b1; predValid = 1'b0; predPC = '0;
    updValid = 1'b0; updPC = '0; updTaken = 1'b0; updPredicted = 1'b0;

    // Saturation/same-index vectors; each row is one cycle, expectations after its edge
    //            uv    ut    up    upc      pv    ppc      rv    ps
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h0,  1'b0, 2'b10};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h0,  1'b0, 2'b10};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h14, 1'b0, 32'h0,  1'b0, 2'b10};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 2'b11};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 32'h0,  1'b0, 2'b11};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 32'h0,  1'b0, 2'b11};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b0, 32'h0,  1'b0, 2'b11};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b0, 32'h0,  1'b0, 2'b11};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 2'b00};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h14, 1'b0, 32'h0,  1'b0, 2'b00};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 2'b01};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20, 1'b1, 2'b10};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h20, 1'b1, 2'b01};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h17, 1'b1, 2'b01};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h20, 1'b1, 2'b10};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 32'h120, 1'b1, 2'b10};

    // Reset values
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_predReady", 32'(predReady), 32'd0);
    check("rst_updReady", 32'(updReady), 32'd0);
    check("rst_respValid", 32'(predRespValid), 32'd0);
    check("rst_prediction", 32'(prediction), 32'd0);
    check("rst_predState", 32'(predState), 32'd0);
    check("rst_predCount", 32'(predCount), 32'd0);
    check("rst_mispredCount", 32'(mispredCount), 32'd0);

    // Init sweep length and readiness
    reset = 1'b0;
    wait_init(cycles);
    check("init_cycles", 32'(cycles), 32'd64);
    check("run_predReady", 32'(predReady), 32'd1);
    check("run_updReady", 32'(updReady), 32'd1);
    sweep_check("sweep_after_reset");

    // Table-driven update/lookup vectors
    for (int i = 0; i < 16; i++) begin
      updValid = vecs[i].uv; updTaken = vecs[i].ut; updPredicted = vecs[i].up;
      updPC = vecs[i].upc; predValid = vecs[i].pv; predPC = vecs[i].ppc;
      step();
      check($sformatf("vec%0d_respValid", i), 32'(predRespValid), 32'(vecs[i].exp_rv));
      check($sformatf("vec%0d_predState", i), 32'(predState), 32'(vecs[i].exp_ps));
      check($sformatf("vec%0d_prediction", i), 32'(prediction), 32'(vecs[i].exp_ps[1]));
    end
    updValid = 1'b0; predValid = 1'b0;

    // Reset mid-sweep at idx=20, then requests presented during INIT
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    check("midsweep_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    predValid = 1'b1; predPC = 32'h14;
    updValid = 1'b1; updPC = 32'h14; updTaken = 1'b0; updPredicted = 1'b1;
    cycles = 0; resp_seen = 0;
    while (busy && cycles < 200) begin
      step();
      cycles++;
      if (predRespValid) resp_seen++;
      if (cycles == 10) begin
        predValid = 1'b0;
        updValid  = 1'b0;
      end
    end
    check("midsweep_init_cycles", 32'(cycles), 32'd64);
    check("init_req_no_resp", 32'(resp_seen), 32'd0);
    check("init_predCount", 32'(predCount), 32'd0);
    check("init_mispredCount", 32'(mispredCount), 32'd0);
    check("init_respValid", 32'(predRespValid), 32'd0);
    sweep_check("sweep_after_midsweep");

    // Statistics: 10 lookups + 10 updates with mismatches at i=2,5,7
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_init(cycles);
    check("stats_init_cycles", 32'(cycles), 32'd64);
    for (int i = 0; i < 10; i++) begin
      predValid = 1'b1; predPC = 32'(i) << 2;
      updValid = 1'b1; updPC = 32'(i) << 2;
      updTaken = 1'(i % 2);
      updPredicted = (i == 2 || i == 5 || i == 7) ? ~updTaken : updTaken;
      step();
    end
    predValid = 1'b0; updValid = 1'b0;
    step();
    check("stats_predCount", 32'(predCount), 32'd10);
    check("stats_mispredCount", 32'(mispredCount), 32'd3);

    // predCount saturation: bring to 0xFFFE, then three more lookups
    predValid = 1'b1; predPC = 32'h40;
    repeat (65524) @(posedge clk);
    #1;
    check("predCount_fffe", 32'(predCount), 32'h0000_FFFE);
    repeat (3) @(posedge clk);
    #1;
    predValid = 1'b0;
    check("predCount_sat", 32'(predCount), 32'h0000_FFFF);
    check("mispred_unchanged", 32'(mispredCount), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
